// File: rtl/ppu_mon_pkg.sv
// Shared constants and tile decode for the PPU pattern-fetch monitor.
package ppu_mon_pkg;

    localparam logic [9:0] TILE_0FD = 10'h0FD;
    localparam logic [9:0] TILE_0FE = 10'h0FE;
    localparam logic [9:0] TILE_1FD = 10'h1FD;
    localparam logic [9:0] TILE_1FE = 10'h1FE;

    // oe_sh history, bit 0 newest: three low samples after a high, then the first high after a low
    localparam logic [3:0] OE_CAPTURE = 4'b1000;
    localparam logic [3:0] OE_COMMIT  = 4'b0001;

    typedef struct packed {
        logic hit;
        logic bank;
        logic val;
    } tile_dec_t;

    function automatic tile_dec_t decode_tile(input logic [9:0] addr);
        tile_dec_t d;
        d = '0;
        case (addr)
            TILE_0FD: begin d.hit = 1'b1; d.bank = 1'b0; d.val = 1'b0; end
            TILE_0FE: begin d.hit = 1'b1; d.bank = 1'b0; d.val = 1'b1; end
            TILE_1FD: begin d.hit = 1'b1; d.bank = 1'b1; d.val = 1'b0; end
            TILE_1FE: begin d.hit = 1'b1; d.bank = 1'b1; d.val = 1'b1; end
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with selectable reset value and a hold enable.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else if (i_en) begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/chr_latch_mon.sv
// PPU bus monitor: MMC2/MMC4 CHR latch tracking from $FD/$FE tile fetches,
// plus an M2-filtered A12 rising-edge strobe for scanline counters.
module chr_latch_mon
    import ppu_mon_pkg::*;
#(
    parameter int A12_LOW_MIN = 3
) (
    input  logic        i_clk,
    input  logic        i_map_rst,
    input  logic        i_ppu_oe,
    input  logic [13:0] i_ppu_addr,
    input  logic        i_m2,
    input  logic        i_ss_act,
    input  logic        i_ss_we,
    input  logic [1:0]  i_ss_dat,
    output logic        o_latch_0,
    output logic        o_latch_1,
    output logic        o_latch_evt,
    output logic        o_a12_rise
);

    localparam int CNT_W = $clog2(A12_LOW_MIN + 1);
    localparam logic [CNT_W-1:0] LOW_MAX = CNT_W'(A12_LOW_MIN);

    logic w_oe_s;
    logic w_a12_s;
    logic w_m2_s;
    logic w_sync_en;
    logic w_m2_fall;
    logic w_a12_qual;
    logic w_unused_addr;
    tile_dec_t w_dec;

    logic [3:0]       r_oe_sh;
    logic [9:0]       r_cap_addr;
    logic             r_cap_valid;
    logic             r_latch_0;
    logic             r_latch_1;
    logic             r_latch_evt;
    logic             r_a12_rise;
    logic             r_a12_d;
    logic             r_m2_d;
    logic [CNT_W-1:0] r_low_cnt;
    logic             r_ss_d;

    assign w_sync_en     = ~i_ss_act;
    assign w_unused_addr = ^i_ppu_addr[3:0];

    sync2 #(.RST_VAL(1'b1)) u_sync_oe (
        .i_clk (i_clk),
        .i_rst (i_map_rst),
        .i_en  (w_sync_en),
        .i_d   (i_ppu_oe),
        .o_q   (w_oe_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_a12 (
        .i_clk (i_clk),
        .i_rst (i_map_rst),
        .i_en  (w_sync_en),
        .i_d   (i_ppu_addr[12]),
        .o_q   (w_a12_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_m2 (
        .i_clk (i_clk),
        .i_rst (i_map_rst),
        .i_en  (w_sync_en),
        .i_d   (i_m2),
        .o_q   (w_m2_s)
    );

    always_comb begin
        w_dec      = decode_tile(r_cap_addr);
        w_m2_fall  = r_m2_d & ~w_m2_s;
        // qualification uses the count before this cycle's M2 fall is added
        w_a12_qual = w_a12_s & ~r_a12_d & (r_low_cnt == LOW_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (i_map_rst) begin
            r_oe_sh     <= 4'b1111;
            r_cap_addr  <= '0;
            r_cap_valid <= 1'b0;
            r_latch_0   <= 1'b0;
            r_latch_1   <= 1'b0;
            r_latch_evt <= 1'b0;
            r_a12_rise  <= 1'b0;
            r_a12_d     <= 1'b0;
            r_m2_d      <= 1'b0;
            r_low_cnt   <= '0;
            r_ss_d      <= 1'b0;
        end else if (i_ss_act) begin
            r_ss_d      <= 1'b1;
            r_latch_evt <= 1'b0;
            r_a12_rise  <= 1'b0;
            if (i_ss_we) begin
                {r_latch_0, r_latch_1} <= i_ss_dat;
            end
        end else begin
            r_ss_d      <= 1'b0;
            r_oe_sh     <= {r_oe_sh[2:0], w_oe_s};
            r_a12_d     <= w_a12_s;
            r_m2_d      <= w_m2_s;
            r_latch_evt <= 1'b0;
            r_a12_rise  <= 1'b0;
            if (r_ss_d) begin
                // first cycle after a freeze: drop anything captured before it
                r_cap_valid <= 1'b0;
                r_low_cnt   <= '0;
            end else begin
                if (r_oe_sh == OE_CAPTURE) begin
                    r_cap_addr  <= i_ppu_addr[13:4];
                    r_cap_valid <= 1'b1;
                end else if ((r_oe_sh == OE_COMMIT) && r_cap_valid) begin
                    r_cap_valid <= 1'b0;
                    if (w_dec.hit) begin
                        r_latch_evt <= 1'b1;
                        if (w_dec.bank) begin
                            r_latch_1 <= w_dec.val;
                        end else begin
                            r_latch_0 <= w_dec.val;
                        end
                    end
                end

                if (w_a12_s) begin
                    r_low_cnt <= '0;
                end else if (w_m2_fall && (r_low_cnt != LOW_MAX)) begin
                    r_low_cnt <= r_low_cnt + CNT_W'(1);
                end

                r_a12_rise <= w_a12_qual;
            end
        end
    end

    assign o_latch_0   = r_latch_0;
    assign o_latch_1   = r_latch_1;
    assign o_latch_evt = r_latch_evt;
    assign o_a12_rise  = r_a12_rise;

endmodule

// File: tb/tb_chr_latch_mon.sv
// Directed bench for chr_latch_mon: latch decode/latency, short windows,
// A12 filter boundaries, save-state freeze and mid-window reset.
module tb_chr_latch_mon;

    logic        clk = 1'b0;
    logic        map_rst;
    logic        ppu_oe;
    logic [13:0] ppu_addr;
    logic        m2;
    logic        ss_act;
    logic        ss_we;
    logic [1:0]  ss_dat;
    logic        latch_0;
    logic        latch_1;
    logic        latch_evt;
    logic        a12_rise;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    always #5 clk = ~clk;

    chr_latch_mon #(.A12_LOW_MIN(3)) dut (
        .i_clk      (clk),
        .i_map_rst  (map_rst),
        .i_ppu_oe   (ppu_oe),
        .i_ppu_addr (ppu_addr),
        .i_m2       (m2),
        .i_ss_act   (ss_act),
        .i_ss_we    (ss_we),
        .i_ss_dat   (ss_dat),
        .o_latch_0  (latch_0),
        .o_latch_1  (latch_1),
        .o_latch_evt(latch_evt),
        .o_a12_rise (a12_rise)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // OE-low window of 'low' cycles, then OE high; tick 1 after the rise is edge k
    task automatic fetch(input string tag, input logic [13:0] a, input int low,
                         input int exp_cnt, input int exp_cyc);
        int n;
        int first;
        n = 0;
        first = -1;
        ppu_addr = a;
        ppu_oe = 1'b0;
        repeat (low) begin
            tick;
            if (latch_evt !== 1'b0) n++;
        end
        ppu_oe = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (latch_evt !== 1'b0) begin
                n++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_evt_cnt"}, n, exp_cnt);
        chk({tag, "_evt_cyc"}, first, exp_cyc);
    endtask

    task automatic m2_falls(input int n);
        repeat (n) begin
            m2 = 1'b1;
            repeat (3) tick;
            m2 = 1'b0;
            repeat (3) tick;
        end
    endtask

    // tick 1 is edge k, the first edge sampling A12 high
    task automatic watch_rise(input string tag, input int exp_cnt, input int exp_cyc);
        int n;
        int first;
        n = 0;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (a12_rise !== 1'b0) begin
                n++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_cnt"}, n, exp_cnt);
        chk({tag, "_cyc"}, first, exp_cyc);
    endtask

    initial begin
        map_rst  = 1'b1;
        ppu_oe   = 1'b1;
        ppu_addr = 14'h0000;
        m2       = 1'b0;
        ss_act   = 1'b0;
        ss_we    = 1'b0;
        ss_dat   = 2'b00;
        repeat (3) tick;
        chk("rst_latch_0", latch_0, 0);
        chk("rst_latch_1", latch_1, 0);
        chk("rst_evt", latch_evt, 0);
        chk("rst_rise", a12_rise, 0);
        map_rst = 1'b0;
        repeat (2) tick;

        // latch decode and commit latency
        fetch("f_0fd0", 14'h0FD0, 6, 1, 4);
        chk("f_0fd0_l0", latch_0, 0);
        fetch("short_0fe0", 14'h0FE0, 2, 0, -1);
        chk("short_l0", latch_0, 0);
        fetch("f_0fe8", 14'h0FE8, 6, 1, 4);
        chk("f_0fe8_l0", latch_0, 1);
        fetch("f_1fe0", 14'h1FE0, 6, 1, 4);
        chk("f_1fe0_l1", latch_1, 1);
        chk("f_1fe0_l0", latch_0, 1);
        fetch("f_1fd3", 14'h1FD3, 6, 1, 4);
        chk("f_1fd3_l1", latch_1, 0);
        chk("f_1fd3_l0", latch_0, 1);
        fetch("f_0fc0", 14'h0FC0, 6, 0, -1);
        chk("f_0fc0_l0", latch_0, 1);
        chk("f_0fc0_l1", latch_1, 0);
        fetch("f3_0fd0", 14'h0FD0, 3, 1, 4);
        chk("f3_0fd0_l0", latch_0, 0);

        // A12 filter
        ppu_addr = 14'h0000;
        repeat (4) tick;
        m2_falls(3);
        ppu_addr = 14'h1000;
        watch_rise("a12_3falls", 1, 3);

        ppu_addr = 14'h0000;
        repeat (4) tick;
        m2_falls(2);
        ppu_addr = 14'h1000;
        watch_rise("a12_2falls", 0, -1);

        ppu_addr = 14'h0000;
        repeat (4) tick;
        m2_falls(5);
        ppu_addr = 14'h1000;
        watch_rise("a12_sat", 1, 3);

        cnt = 0;
        repeat (6) begin
            ppu_addr = 14'h0000;
            repeat (4) begin tick; if (a12_rise !== 1'b0) cnt++; end
            ppu_addr = 14'h1000;
            repeat (4) begin tick; if (a12_rise !== 1'b0) cnt++; end
        end
        chk("a12_no_m2", cnt, 0);

        ppu_addr = 14'h0000;
        repeat (4) tick;
        m2_falls(2);
        m2 = 1'b1;
        repeat (3) tick;
        m2 = 1'b0;
        ppu_addr = 14'h1000;
        watch_rise("a12_simul", 0, -1);

        // save-state freeze with a captured but uncommitted fetch
        fetch("pre_ss_0fd0", 14'h0FD0, 6, 1, 4);
        fetch("pre_ss_1fe0", 14'h1FE0, 6, 1, 4);
        chk("pre_ss_l0", latch_0, 0);
        chk("pre_ss_l1", latch_1, 1);
        cnt = 0;
        ppu_addr = 14'h0FD0;
        ppu_oe = 1'b0;
        repeat (6) begin tick; if (latch_evt !== 1'b0) cnt++; end
        ss_act = 1'b1;
        ss_we  = 1'b1;
        ss_dat = 2'b10;
        tick;
        ss_we = 1'b0;
        repeat (2) begin tick; if ((latch_evt | a12_rise) !== 1'b0) cnt++; end
        ppu_oe = 1'b1;
        repeat (4) begin tick; if ((latch_evt | a12_rise) !== 1'b0) cnt++; end
        chk("ss_l0", latch_0, 1);
        chk("ss_l1", latch_1, 0);
        ss_act = 1'b0;
        repeat (10) begin tick; if (latch_evt !== 1'b0) cnt++; end
        chk("ss_no_evt", cnt, 0);
        chk("ss_post_l0", latch_0, 1);
        chk("ss_post_l1", latch_1, 0);

        // reset in the middle of a window after capture
        cnt = 0;
        ppu_addr = 14'h1FE0;
        ppu_oe = 1'b0;
        repeat (6) tick;
        map_rst = 1'b1;
        tick;
        ppu_oe = 1'b1;
        repeat (2) tick;
        chk("mrst_l0", latch_0, 0);
        chk("mrst_l1", latch_1, 0);
        map_rst = 1'b0;
        repeat (8) begin tick; if (latch_evt !== 1'b0) cnt++; end
        chk("mrst_no_evt", cnt, 0);
        chk("mrst_post_l1", latch_1, 0);
        fetch("post_rst_1fe0", 14'h1FE0, 6, 1, 4);
        chk("post_rst_l1", latch_1, 1);
        chk("post_rst_l0", latch_0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
